// File: rtl/dmem_responder.sv
// dmem_responder: word-addressed data memory with a fixed, programmable
// access latency. It takes one request at a time over a valid/ready request
// channel and returns one response over a valid/ready response channel.
module dmem_responder #(
    parameter int DEPTH   = 256,  // words; power of two, >= 2
    parameter int LATENCY = 2     // 1..15
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        busy
);

    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t      state;
    logic [3:0]  cnt;
    logic        lat_write;
    logic [31:0] lat_addr;
    logic [31:0] lat_wdata;

    // Storage is deliberately left without reset so it can map onto RAM.
    logic [31:0] mem [DEPTH];

    logic          accept;
    logic          do_access;
    logic          acc_write;
    logic [31:0]   acc_addr;
    logic [31:0]   acc_wdata;
    logic          acc_in_range;
    logic [AW-1:0] acc_idx;

    assign req_ready = (state == IDLE);
    assign busy      = (state != IDLE);
    assign accept    = req_ready && req_valid;

    // Access operands: with LATENCY=1 the access happens on the accept edge,
    // so the live request inputs are used; otherwise the latched copy.
    always_comb begin
        acc_write = lat_write;
        acc_addr  = lat_addr;
        acc_wdata = lat_wdata;
        if (state == IDLE) begin
            acc_write = req_write;
            acc_addr  = req_addr;
            acc_wdata = req_wdata;
        end
        // Reset is ANDed in so a request presented while reset is held can
        // never reach the array.
        do_access    = !reset && (((LATENCY == 1) && accept) ||
                                  ((state == WAIT) && (cnt == 4'd1)));
        // Full 32-bit compare: addresses past DEPTH never alias.
        acc_in_range = (acc_addr < 32'(DEPTH));
        acc_idx      = acc_addr[AW-1:0];
    end

    // Store commit; out-of-range stores are dropped.
    always_ff @(posedge clock) begin
        if (do_access && acc_write && acc_in_range)
            mem[acc_idx] <= acc_wdata;
    end

    // Request/response FSM with registered response outputs.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            cnt        <= 4'd0;
            lat_write  <= 1'b0;
            lat_addr   <= 32'd0;
            lat_wdata  <= 32'd0;
            resp_valid <= 1'b0;
            resp_rdata <= 32'd0;
            resp_err   <= 1'b0;
        end else begin
            // Load data is the pre-write word at the commit edge.
            if (do_access) begin
                resp_valid <= 1'b1;
                resp_err   <= !acc_in_range;
                resp_rdata <= (acc_in_range && !acc_write) ? mem[acc_idx] : 32'd0;
            end
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        lat_write <= req_write;
                        lat_addr  <= req_addr;
                        lat_wdata <= req_wdata;
                        cnt       <= 4'(LATENCY - 1);
                        state     <= (LATENCY > 1) ? WAIT : RESP;
                    end
                end
                WAIT: begin
                    cnt <= cnt - 4'd1;
                    if (cnt == 4'd1)
                        state <= RESP;
                end
                RESP: begin
                    if (resp_ready) begin
                        resp_valid <= 1'b0;
                        resp_err   <= 1'b0;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: three instances (LATENCY 2, 1, 4) driven from one
// stimulus thread; a monitor thread pops scoreboard entries on responses.
module tb_dmem_responder;

    localparam int NI = 3;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          acc;   // edge count at which the request was accepted
    } exp_t;

    logic clock = 1'b0;
    logic reset;
    logic [NI-1:0]       req_valid, req_ready, req_write;
    logic [NI-1:0]       resp_valid, resp_ready, resp_err, busy;
    logic [NI-1:0][31:0] req_addr, req_wdata, resp_rdata;

    int   checks = 0;
    int   errs   = 0;
    int   cyc    = 0;
    bit   rnd_rdy = 0;

    exp_t        sb [NI][$];
    bit   [31:0] mm [NI][256];
    bit          wr [NI][256];

    bit          pv   [NI];
    bit          pend [NI];
    logic [31:0] hr   [NI];
    logic        he   [NI];

    always #5 clock = ~clock;

    // Number of rising edges seen so far.
    always @(posedge clock) cyc <= cyc + 1;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        dmem_responder #(
            .DEPTH  (256),
            .LATENCY(g == 0 ? 2 : (g == 1 ? 1 : 4))
        ) u_dut (
            .clock     (clock),
            .reset     (reset),
            .req_valid (req_valid[g]),
            .req_ready (req_ready[g]),
            .req_write (req_write[g]),
            .req_addr  (req_addr[g]),
            .req_wdata (req_wdata[g]),
            .resp_valid(resp_valid[g]),
            .resp_ready(resp_ready[g]),
            .resp_rdata(resp_rdata[g]),
            .resp_err  (resp_err[g]),
            .busy      (busy[g])
        );
    end

    function automatic int lat_of(int i);
        return (i == 0) ? 2 : ((i == 1) ? 1 : 4);
    endfunction

    // Reference: a word array plus the out-of-range rule.
    function automatic exp_t model(int i, bit w, logic [31:0] a, logic [31:0] d, int acc);
        exp_t e;
        e.acc   = acc;
        e.err   = (a >= 32'd256);
        e.rdata = 32'd0;
        if (!e.err) begin
            if (w) begin
                mm[i][a[7:0]] = d;
                wr[i][a[7:0]] = 1'b1;
            end else begin
                e.rdata = mm[i][a[7:0]];
            end
        end
        return e;
    endfunction

    task automatic step();
        @(posedge clock);
        #1;
        if (rnd_rdy)
            for (int k = 0; k < NI; k++) resp_ready[k] = 1'($urandom_range(0, 1));
    endtask

    task automatic issue(input int i, input bit w, input logic [31:0] a,
                         input logic [31:0] d, output int acc);
        int n;
        n   = 0;
        acc = -1;
        while (!req_ready[i] && n < 60) begin
            step();
            n++;
        end
        if (!req_ready[i]) begin
            checks++; errs++;
            $display("FAIL issue_timeout inst %0d: req_ready=0 after 60 cycles, want 1", i);
            return;
        end
        req_valid[i] = 1'b1;
        req_write[i] = w;
        req_addr[i]  = a;
        req_wdata[i] = d;
        step();
        acc = cyc;
        sb[i].push_back(model(i, w, a, d, acc));
        req_valid[i] = 1'b0;
        req_write[i] = 1'($urandom_range(0, 1));
        req_addr[i]  = $urandom;
        req_wdata[i] = $urandom;
    endtask

    task automatic wait_idle(input int i);
        int n;
        n = 0;
        while ((busy[i] || sb[i].size() != 0) && n < 100) begin
            step();
            n++;
        end
        if (busy[i] || sb[i].size() != 0) begin
            checks++; errs++;
            $display("FAIL idle_timeout inst %0d: busy=%0b pending=%0d, want 0/0",
                     i, busy[i], sb[i].size());
        end
    endtask

    task automatic check_reset(input string nm);
        for (int i = 0; i < NI; i++) begin
            checks++;
            if (req_ready[i] !== 1'b1 || resp_valid[i] !== 1'b0 || resp_rdata[i] !== 32'd0 ||
                resp_err[i] !== 1'b0 || busy[i] !== 1'b0) begin
                errs++;
                $display("FAIL %s inst %0d: rdy=%b vld=%b rdata=%h err=%b busy=%b, want 1 0 0 0 0",
                         nm, i, req_ready[i], resp_valid[i], resp_rdata[i], resp_err[i], busy[i]);
            end
        end
    endtask

    // Response monitor: latency, data, hold-while-stalled, return to IDLE.
    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge clock);
            for (int i = 0; i < NI; i++) begin
                if (reset) begin
                    pv[i]   = 1'b0;
                    pend[i] = 1'b0;
                end else begin
                    if (pend[i]) begin
                        checks++;
                        if (resp_valid[i] !== 1'b0 || req_ready[i] !== 1'b1) begin
                            errs++;
                            $display("FAIL retire_idle inst %0d: vld=%b rdy=%b, want 0 1",
                                     i, resp_valid[i], req_ready[i]);
                        end
                        pend[i] = 1'b0;
                    end
                    if (resp_valid[i]) begin
                        if (!pv[i]) begin
                            if (sb[i].size() == 0) begin
                                checks++; errs++;
                                $display("FAIL unexpected_resp inst %0d: rdata=%h err=%b, want none",
                                         i, resp_rdata[i], resp_err[i]);
                            end else begin
                                e = sb[i][0];
                                checks++;
                                // The accept edge is the first of LATENCY edges.
                                if (cyc - e.acc != lat_of(i) - 1) begin
                                    errs++;
                                    $display("FAIL latency inst %0d: %0d edges after accept, want %0d",
                                             i, cyc - e.acc, lat_of(i) - 1);
                                end
                                checks++;
                                if (resp_rdata[i] !== e.rdata || resp_err[i] !== e.err) begin
                                    errs++;
                                    $display("FAIL resp_data inst %0d: rdata=%h err=%b, want %h %b",
                                             i, resp_rdata[i], resp_err[i], e.rdata, e.err);
                                end
                            end
                            hr[i] = resp_rdata[i];
                            he[i] = resp_err[i];
                        end else begin
                            checks++;
                            if (resp_rdata[i] !== hr[i] || resp_err[i] !== he[i] || req_ready[i]) begin
                                errs++;
                                $display("FAIL resp_hold inst %0d: rdata=%h err=%b rdy=%b, want %h %b 0",
                                         i, resp_rdata[i], resp_err[i], req_ready[i], hr[i], he[i]);
                            end
                        end
                        if (resp_ready[i]) begin
                            if (sb[i].size() != 0) void'(sb[i].pop_front());
                            pend[i] = 1'b1;
                        end
                    end
                    pv[i] = resp_valid[i];
                end
            end
        end
    endtask

    task automatic run_tests();
        int a1, a2, n, i, ad;
        bit w;
        reset      = 1'b1;
        req_valid  = '0;
        req_write  = '0;
        req_addr   = '0;
        req_wdata  = '0;
        resp_ready = '0;
        repeat (3) step();
        check_reset("reset_values");
        reset = 1'b0;
        step();

        // Store then load on LATENCY=2.
        resp_ready = '1;
        issue(0, 1'b1, 32'd5, 32'hDEADBEEF, a1);
        checks++;
        if (req_ready[0] !== 1'b0) begin
            errs++;
            $display("FAIL ready_drop inst 0: req_ready=%b, want 0", req_ready[0]);
        end
        issue(0, 1'b0, 32'd5, 32'd0, a1);
        wait_idle(0);

        // LATENCY=1 back-to-back store/load with resp_ready held high.
        issue(1, 1'b1, 32'd0, 32'h5A5A_0001, a1);
        issue(1, 1'b0, 32'd0, 32'd0, a2);
        checks++;
        if (a2 - a1 != 2) begin
            errs++;
            $display("FAIL accept_spacing inst 1: %0d cycles, want 2", a2 - a1);
        end
        wait_idle(1);

        // Out-of-range store and load; addr 0 must survive.
        issue(0, 1'b1, 32'd0, 32'h0BADF00D, a1);
        issue(0, 1'b1, 32'd256, 32'h1234, a1);
        issue(0, 1'b0, 32'hFFFFFFFF, 32'd0, a1);
        issue(0, 1'b0, 32'd0, 32'd0, a1);
        wait_idle(0);

        // Backpressure with req_* toggling while RESP is held.
        resp_ready[0] = 1'b0;
        issue(0, 1'b0, 32'd5, 32'd0, a1);
        n = 0;
        while (!resp_valid[0] && n < 20) begin
            step();
            n++;
        end
        checks++;
        if (!resp_valid[0]) begin
            errs++;
            $display("FAIL bp_resp inst 0: resp_valid=0 after 20 cycles, want 1");
        end
        repeat (5) begin
            req_valid[0] = 1'b1;
            req_write[0] = 1'($urandom_range(0, 1));
            req_addr[0]  = 32'($urandom_range(0, 7));
            req_wdata[0] = $urandom;
            step();
        end
        req_valid[0]  = 1'b0;
        resp_ready[0] = 1'b1;
        wait_idle(0);
        issue(0, 1'b0, 32'd5, 32'd0, a1);
        wait_idle(0);

        // Reset in the middle of a LATENCY=4 store.
        issue(2, 1'b1, 32'd7, 32'h1, a1);
        wait_idle(2);
        req_valid[2] = 1'b1;
        req_write[2] = 1'b1;
        req_addr[2]  = 32'd7;
        req_wdata[2] = 32'hAAAA5555;
        step();
        req_valid[2] = 1'b0;
        step();
        checks++;
        if (busy[2] !== 1'b1) begin
            errs++;
            $display("FAIL in_wait inst 2: busy=%b, want 1", busy[2]);
        end
        #2 reset = 1'b1;
        #1 check_reset("reset_async");
        step();
        step();
        reset = 1'b0;
        step();
        issue(2, 1'b0, 32'd7, 32'd0, a1);
        wait_idle(2);

        // Randomized traffic with random response backpressure.
        rnd_rdy = 1'b1;
        for (int t = 0; t < 150; t++) begin
            i  = int'($urandom_range(0, NI - 1));
            w  = 1'($urandom_range(0, 1));
            ad = int'($urandom_range(0, 15));
            if (!w && !wr[i][ad]) w = 1'b1;
            if ($urandom_range(0, 4) == 0)
                issue(i, w, 32'h100 | $urandom, $urandom, a1);
            else
                issue(i, w, 32'(ad), $urandom, a1);
        end
        rnd_rdy    = 1'b0;
        resp_ready = '1;
        for (int k = 0; k < NI; k++) wait_idle(k);
        step();
    endtask

    initial begin
        fork
            monitor();
            run_tests();
        join_any
        $display("CHECKS %0d ERRORS %0d", checks, errs);
        $finish;
    end

endmodule
